// File: rtl/counter_gate_sequencer.sv
// Gate/clear strobe sequencer for the photon counter: runs a programmed series of
// fixed-length counting windows and queues each window's count in a show-ahead FIFO.
module counter_gate_sequencer #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [31:0]      i_gate_len,
    input  logic [15:0]      i_num_gates,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_cnt_reset,
    output logic             o_gate,
    output logic             o_busy,
    output logic [15:0]      o_gates_done,
    input  logic             i_rd_en,
    output logic [CNT_W-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StGate,
        StSettle,
        StCapture
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      len_q, len_d;
    logic [15:0]      num_q, num_d;
    logic [31:0]      gate_cnt_q, gate_cnt_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [15:0]      done_q, done_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic             gate_q, gate_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] mem [DEPTH];

    logic start_ok;
    logic push_req;
    logic push_ok;
    logic pop;

    // Window sequencing
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        num_d        = num_q;
        gate_cnt_d   = gate_cnt_q;
        settle_cnt_d = settle_cnt_q;
        done_d       = done_q;
        start_ok     = 1'b0;
        push_req     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start && !i_stop) begin
                    start_ok = 1'b1;
                    len_d    = (i_gate_len == 32'd0) ? 32'd1 : i_gate_len;
                    num_d    = i_num_gates;
                    done_d   = 16'd0;
                    state_d  = StClr;
                end
            end
            StClr: begin
                gate_cnt_d = len_q - 32'd1;
                state_d    = StGate;
            end
            StGate: begin
                if (gate_cnt_q == 32'd0) begin
                    settle_cnt_d = SW'(SETTLE_CYC - 1);
                    state_d      = StSettle;
                end else begin
                    gate_cnt_d = gate_cnt_q - 32'd1;
                end
            end
            StSettle: begin
                if (settle_cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    settle_cnt_d = settle_cnt_q - SW'(1);
                end
            end
            StCapture: begin
                push_req = 1'b1;
                done_d   = done_q + 16'd1;
                if (num_q != 16'd0 && done_d == num_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StClr;
                end
            end
            default: state_d = StIdle;
        endcase

        // An abort discards the window in flight, including a capture this cycle.
        if (state_q != StIdle && i_stop) begin
            state_d  = StIdle;
            push_req = 1'b0;
            done_d   = done_q;
        end

        cnt_reset_d = (state_d == StClr);
        gate_d      = (state_d == StGate);
        busy_d      = (state_d != StIdle);
    end

    // Result FIFO
    always_comb begin
        pop      = i_rd_en && !empty_q;
        push_ok  = push_req && (!full_q || pop);
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

        // Head comes from the incoming word when it lands in the slot being exposed.
        rd_data_d = rd_data_q;
        if (!empty_d) begin
            if (push_ok && rd_ptr_d == wr_ptr_q) begin
                rd_data_d = i_count;
            end else begin
                rd_data_d = mem[rd_ptr_d[AW-1:0]];
            end
        end

        overflow_d = overflow_q;
        if (start_ok) begin
            overflow_d = 1'b0;
        end else if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StIdle;
            len_q        <= 32'd1;
            num_q        <= 16'd0;
            gate_cnt_q   <= 32'd0;
            settle_cnt_q <= '0;
            done_q       <= 16'd0;
            cnt_reset_q  <= 1'b0;
            gate_q       <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            num_q        <= num_d;
            gate_cnt_q   <= gate_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            done_q       <= done_d;
            cnt_reset_q  <= cnt_reset_d;
            gate_q       <= gate_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_data_q    <= rd_data_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= i_count;
        end
    end

    assign o_cnt_reset  = cnt_reset_q;
    assign o_gate       = gate_q;
    assign o_busy       = busy_q;
    assign o_gates_done = done_q;
    assign o_rd_data    = rd_data_q;
    assign o_empty      = empty_q;
    assign o_full       = full_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_counter_gate_sequencer.sv
// Directed and randomized bench for counter_gate_sequencer; a window-offset reference
// model predicts every output each cycle.
module tb_counter_gate_sequencer;

    localparam int CNT_W      = 32;
    localparam int DEPTH      = 16;
    localparam int SETTLE_CYC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic [31:0]      gl;
    logic [15:0]      nm;
    logic [CNT_W-1:0] cnt;
    logic             rd_en;
    logic             o_cnt_reset;
    logic             o_gate;
    logic             o_busy;
    logic [15:0]      o_gates_done;
    logic [CNT_W-1:0] o_rd_data;
    logic             o_empty;
    logic             o_full;
    logic             o_overflow;

    always #5 clk = ~clk;

    counter_gate_sequencer #(
        .CNT_W      (CNT_W),
        .DEPTH      (DEPTH),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_gate_len   (gl),
        .i_num_gates  (nm),
        .i_count      (cnt),
        .o_cnt_reset  (o_cnt_reset),
        .o_gate       (o_gate),
        .o_busy       (o_busy),
        .o_gates_done (o_gates_done),
        .i_rd_en      (rd_en),
        .o_rd_data    (o_rd_data),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_overflow   (o_overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: run position is a cycle offset since start, window = offset/period.
    bit               m_busy = 1'b0;
    longint           m_k    = 0;
    longint           m_len  = 1;
    logic [15:0]      m_num  = 16'd0;
    logic [15:0]      m_done = 16'd0;
    bit               m_ovf  = 1'b0;
    logic [CNT_W-1:0] m_q[$];

    int               cnt_mode = 0;
    logic [CNT_W-1:0] cnt_stub = '0;
    int               gate_hi  = 0;
    int               rst_hits = 0;
    longint           cyc      = 0;
    longint           rst_cyc[$];

    function automatic longint m_period();
        return m_len + SETTLE_CYC + 2;
    endfunction

    function automatic longint m_off();
        return m_k % m_period();
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit cap;
        bit push;
        if (rst) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_done = 16'd0;
            m_ovf  = 1'b0;
            m_q.delete();
        end else begin
            cap  = m_busy && (m_off() == m_period() - 1);
            push = cap && !stop;
            if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(cnt);
                else m_ovf = 1'b1;
            end
            if (m_busy) begin
                if (stop) begin
                    m_busy = 1'b0;
                end else begin
                    if (cap) begin
                        m_done = m_done + 16'd1;
                        if (m_num != 16'd0 && m_done == m_num) m_busy = 1'b0;
                    end
                    m_k++;
                end
            end else if (start && !stop) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_len  = (gl == 32'd0) ? 1 : longint'(gl);
                m_num  = nm;
                m_done = 16'd0;
                m_ovf  = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        bit e_rst;
        bit e_gate;
        e_rst  = m_busy ? (m_off() == 0) : 1'b0;
        e_gate = m_busy ? (m_off() >= 1 && m_off() <= m_len) : 1'b0;
        chk("busy", 64'(o_busy), 64'(m_busy));
        chk("cnt_reset", 64'(o_cnt_reset), 64'(e_rst));
        chk("gate", 64'(o_gate), 64'(e_gate));
        chk("gates_done", 64'(o_gates_done), 64'(m_done));
        chk("empty", 64'(o_empty), 64'(m_q.size() == 0));
        chk("full", 64'(o_full), 64'(m_q.size() == DEPTH));
        chk("overflow", 64'(o_overflow), 64'(m_ovf));
        if (m_q.size() > 0) chk("rd_data", 64'(o_rd_data), 64'(m_q[0]));
        if (o_gate === 1'b1) gate_hi++;
        if (o_cnt_reset === 1'b1) begin
            rst_hits++;
            rst_cyc.push_back(cyc);
        end
    endtask

    // One clock: model tracks the edge, outputs checked on the falling edge, then the
    // upstream counter stub advances from the (stable) strobes.
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
        if (cnt_mode == 0) begin
            if (o_cnt_reset) cnt_stub = '0;
            else if (o_gate) cnt_stub = cnt_stub + 1'b1;
            cnt = cnt_stub;
        end else begin
            cnt = $urandom;
        end
    endtask

    task automatic run_start(input logic [31:0] len, input logic [15:0] num);
        gl    = len;
        nm    = num;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 64'(o_busy), 64'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!o_empty && n < budget) begin
            rd_en = ($urandom_range(0, 1) == 1);
            tick();
            n++;
        end
        rd_en = 1'b0;
        chk("drain_timeout", 64'(o_empty), 64'd1);
    endtask

    initial begin
        int n;
        int stop_at;
        rst = 1'b1; start = 1'b0; stop = 1'b0; gl = '0; nm = '0; cnt = '0; rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_rd_data", 64'(o_rd_data), 64'd0);

        // Three windows of 10, counter sees one photon per gated cycle
        gate_hi = 0; rst_hits = 0; rst_cyc.delete();
        run_start(32'd10, 16'd3);
        wait_idle(200);
        chk("t1_gate_cycles", 64'(gate_hi), 64'd30);
        chk("t1_clr_pulses", 64'(rst_hits), 64'd3);
        chk("t1_period_a", 64'(rst_cyc[1] - rst_cyc[0]), 64'd16);
        chk("t1_period_b", 64'(rst_cyc[2] - rst_cyc[1]), 64'd16);
        chk("t1_done", 64'(o_gates_done), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_data", 64'(o_rd_data), 64'd10);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("t1_empty", 64'(o_empty), 64'd1);

        // Zero length behaves as one cycle
        gate_hi = 0;
        run_start(32'd0, 16'd1);
        wait_idle(50);
        chk("t2_gate_cycles", 64'(gate_hi), 64'd1);
        chk("t2_nonempty", 64'(o_empty), 64'd0);
        chk("t2_data", 64'(o_rd_data), 64'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;

        // Continuous run with no reads until one capture is dropped
        cnt_mode = 1;
        run_start(32'd5, 16'd0);
        n = 0;
        while (o_gates_done != 16'd17 && n < 400) begin
            tick();
            n++;
        end
        chk("t3_done", 64'(o_gates_done), 64'd17);
        chk("t3_full", 64'(o_full), 64'd1);
        chk("t3_overflow", 64'(o_overflow), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_idle", 64'(o_busy), 64'd0);
        drain(200);

        // Abort on the 4th gated cycle of window 2; new start clears overflow
        cnt_mode = 0;
        run_start(32'd10, 16'd5);
        chk("t5_ovf_cleared", 64'(o_overflow), 64'd0);
        n = 0;
        while (m_k != 20 && n < 60) begin
            tick();
            n++;
        end
        chk("t5_gate_before_stop", 64'(o_gate), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_gate_low", 64'(o_gate), 64'd0);
        chk("t5_done", 64'(o_gates_done), 64'd1);
        chk("t5_one_entry", 64'(o_empty), 64'd0);
        chk("t5_data", 64'(o_rd_data), 64'd10);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t5_now_empty", 64'(o_empty), 64'd1);

        // Capture into a full FIFO with a simultaneous read
        cnt_mode = 1;
        run_start(32'd1, 16'd0);
        n = 0;
        while (!o_full && n < 300) begin
            tick();
            n++;
        end
        chk("t6_filled", 64'(o_full), 64'd1);
        n = 0;
        while (!(m_busy && m_off() == m_period() - 1) && n < 20) begin
            tick();
            n++;
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t6_no_overflow", 64'(o_overflow), 64'd0);
        chk("t6_still_full", 64'(o_full), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain(200);

        // Reset during SETTLE with three results queued
        run_start(32'd3, 16'd0);
        n = 0;
        while (o_gates_done != 16'd3 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (!(m_off() > m_len && m_off() <= m_len + SETTLE_CYC) && n < 20) begin
            tick();
            n++;
        end
        chk("t7_queued", 64'(o_empty), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_busy", 64'(o_busy), 64'd0);
        chk("t7_empty", 64'(o_empty), 64'd1);
        chk("t7_done", 64'(o_gates_done), 64'd0);
        chk("t7_rd_data", 64'(o_rd_data), 64'd0);

        // Start while busy must not disturb the run
        cnt_mode = 0;
        run_start(32'd4, 16'd2);
        tick(); tick(); tick();
        run_start(32'd9, 16'd7);
        gl = '0; nm = '0;
        wait_idle(100);
        chk("t8_done", 64'(o_gates_done), 64'd2);
        for (int i = 0; i < 2; i++) begin
            chk("t8_data", 64'(o_rd_data), 64'd4);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;

        // Randomized runs
        cnt_mode = 1;
        for (int r = 0; r < 8; r++) begin
            run_start(32'($urandom_range(0, 6)), 16'($urandom_range(0, 4)));
            stop_at = $urandom_range(20, 80);
            n = 0;
            while (o_busy && n < 150) begin
                rd_en = ($urandom_range(0, 3) == 0);
                stop  = (m_num == 16'd0 && n == stop_at) || ($urandom_range(0, 49) == 0);
                tick();
                n++;
            end
            rd_en = 1'b0;
            stop  = 1'b0;
            chk("rand_idle_timeout", 64'(o_busy), 64'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_gate_sequencer.md
# counter_gate_sequencer

Sequencer directly upstream and downstream of the photon input counter in the counter project. It generates the counter's gate and reset strobes for a programmable series of fixed-length counting windows. After each window it captures the counter's 32-bit result into a small show-ahead FIFO, which the bus/register side drains. It owns all window timing, so software only programs length and repetition count and reads back results.

## Interface
Parameters:
- CNT_W, 32: width of captured count and FIFO data.
- DEPTH, 16: FIFO depth in entries; power of two, ≥2.
- SETTLE_CYC, 4: cycles between gate fall and capture; covers counter pipeline latency; ≥3.

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  sole clock.
- i_reset  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse; starts a run from IDLE; ignored otherwise.
- i_stop  in  1  abort; honoured in any non-IDLE state.
- i_gate_len  in  32  window length in cycles; sampled on accepted i_start.
- i_num_gates  in  16  windows per run; 0 = continuous until i_stop; sampled on accepted i_start.
- i_count  in  CNT_W  counter result.
- o_cnt_reset  out  1  counter clear strobe.
- o_gate  out  1  counter gate.
- o_busy  out  1  high in every state except IDLE.
- o_gates_done  out  16  windows captured this run (wraps at 2^16).
- i_rd_en  in  1  pop FIFO head.
- o_rd_data  out  CNT_W  FIFO head; valid while !o_empty.
- o_empty  out  1  FIFO empty.
- o_full  out  1  FIFO full.
- o_overflow  out  1  sticky; a capture was dropped.

## Operation
- States: IDLE → CLR → GATE → SETTLE → CAPTURE → (CLR | IDLE).
- IDLE: i_start=1 latches len = max(i_gate_len,1) and num = i_num_gates; clears o_gates_done and o_overflow; goes to CLR.
- CLR: o_cnt_reset=1 for exactly one cycle; go to GATE.
- GATE: o_gate=1 for exactly len cycles, tracked by a 32-bit down-counter; then SETTLE.
- SETTLE: o_gate=0 for SETTLE_CYC cycles; then CAPTURE.
- CAPTURE: one cycle. Push i_count; o_gates_done++. If num≠0 and the new o_gates_done==num, go to IDLE; else go to CLR.
- i_stop in CLR/GATE/SETTLE/CAPTURE: next state IDLE, o_gate=0 next cycle, nothing pushed. An i_stop coinciding with CAPTURE suppresses that push. i_stop has priority over i_start.
- i_start while busy: ignored. Latched len/num are not affected by input changes mid-run.
- FIFO: show-ahead, DEPTH entries, pointers with wrap bit.
  - Push while full (no pop that cycle): entry dropped, o_overflow set.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: ignored.
  - Push and pop in the same cycle while empty: push lands, pop ignored.
- i_reset has priority over everything. Mid-run it returns to IDLE, empties the FIFO and clears all state.
- All outputs are registered.

## Timing
- Reset values: o_cnt_reset=0, o_gate=0, o_busy=0, o_gates_done=0, o_empty=1, o_full=0, o_overflow=0, o_rd_data=0.
- i_start accepted at edge t:
  - o_busy=1 and o_cnt_reset=1 from t+1 for one cycle.
  - o_gate=1 from t+2 through t+1+len.
  - Capture at edge t+2+len+SETTLE_CYC.
  - o_empty falls and o_gates_done increments one cycle after capture.
- Window period: len+SETTLE_CYC+2 cycles. Last window: o_busy falls the cycle after capture.
- i_rd_en at edge t: the next head is on o_rd_data at t+1; o_empty/o_full update at t+1.
- o_overflow is set the cycle after the dropped push and holds until the next accepted i_start or reset.

## Test plan
- len=10, num=3, one input edge per window cycle: three o_cnt_reset pulses, o_gate high 10 cycles each, 16-cycle period, FIFO holds 10,10,10, o_gates_done=3, o_busy low after the third capture.
- i_gate_len=0, num=1: o_gate high exactly 1 cycle, one entry pushed.
- num=0, len=5, no reads, DEPTH=16: after 17 windows o_full=1, 16 entries kept, o_overflow=1. i_stop then returns to IDLE within 1 cycle.
- FIFO full and capture with i_rd_en in the same cycle: no overflow, still full, head advances.
- i_stop on the 4th GATE cycle of window 2: o_gate low next cycle, only 1 entry in FIFO, o_gates_done=1. A following i_start runs normally and clears o_overflow.
- i_reset asserted during SETTLE with 3 entries queued: next cycle all outputs at reset values and o_empty=1. i_start during an active run: no effect on len, num or timing.
